// File: rtl/mux4_pkg.sv
// Shared constants and stage-state type for the 4-to-1 round-robin collector.
package mux4_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 16;

  localparam logic [SEL_W-1:0] SEL_CH0 = 2'b00;
  localparam logic [SEL_W-1:0] SEL_CH1 = 2'b01;
  localparam logic [SEL_W-1:0] SEL_CH2 = 2'b10;
  localparam logic [SEL_W-1:0] SEL_CH3 = 2'b11;

  // The output stage is either empty or holding one beat; FULL is out_valid.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_t;

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin arbiter: grants the first requester
// found scanning upward from last+1, wrapping 3 -> 0.
module rr_arbiter4
  import mux4_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  last,
  output logic [NUM_CH-1:0] gnt_onehot,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              any
);

  // Candidate channel for each priority slot; 2-bit addition wraps mod 4,
  // so the lowest-priority slot is last itself.
  logic [SEL_W-1:0] cand_idx [NUM_CH];
  logic             found;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cand
      assign cand_idx[gi] = last + SEL_W'(gi + 1);
    end
  endgenerate

  // Priority scan over the rotated candidate list.
  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && req[cand_idx[k]]) begin
        gnt_idx = cand_idx[k];
        found   = 1'b1;
      end
    end
  end

  assign any = |req;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_onehot
      assign gnt_onehot[gi] = any && (gnt_idx == SEL_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/mux4_rr_collector.sv
// 4-to-1 round-robin collector with a single registered output stage that
// tags each forwarded word with its source channel code.
module mux4_rr_collector
  import mux4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in_data0,
  input  logic [WIDTH-1:0]  in_data1,
  input  logic [WIDTH-1:0]  in_data2,
  input  logic [WIDTH-1:0]  in_data3,
  input  logic [NUM_CH-1:0] in_valid,
  output logic [NUM_CH-1:0] in_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [SEL_W-1:0]  out_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  beat_cnt
);

  stage_state_t      state_reg, state_next;
  logic [WIDTH-1:0]  data_reg;
  logic [SEL_W-1:0]  sel_reg;
  logic [SEL_W-1:0]  last_grant_reg;
  logic [CNT_W-1:0]  beat_cnt_reg;

  logic [NUM_CH-1:0] gnt_onehot;
  logic [SEL_W-1:0]  gnt_idx;
  logic              any_req;
  logic              stage_free;
  logic              accept;
  logic [WIDTH-1:0]  sel_data;

  rr_arbiter4 u_arb (
    .req        (in_valid),
    .last       (last_grant_reg),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any_req)
  );

  // The stage can take a new beat when empty or when its beat leaves now.
  // Reset blocks the handshake so nothing is accepted at a reset edge.
  assign stage_free = (state_reg == ST_EMPTY) || out_ready;
  assign accept     = !reset && stage_free && any_req;
  assign in_ready   = accept ? gnt_onehot : '0;

  // Route the granted channel's word toward the output register.
  always_comb begin
    sel_data = in_data0;
    case (gnt_idx)
      SEL_CH0: sel_data = in_data0;
      SEL_CH1: sel_data = in_data1;
      SEL_CH2: sel_data = in_data2;
      SEL_CH3: sel_data = in_data3;
      default: sel_data = in_data0;
    endcase
  end

  // Stage occupancy: fill on accept, empty on drain with no replacement.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_EMPTY: if (accept) state_next = ST_FULL;
      ST_FULL:  if (!accept && out_ready) state_next = ST_EMPTY;
      default:  state_next = ST_EMPTY;
    endcase
  end

  // Stage register, grant pointer and beat counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_EMPTY;
      data_reg       <= '0;
      sel_reg        <= SEL_CH0;
      last_grant_reg <= SEL_CH3;
      beat_cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        data_reg       <= sel_data;
        sel_reg        <= gnt_idx;
        last_grant_reg <= gnt_idx;
        beat_cnt_reg   <= beat_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign out_valid = (state_reg == ST_FULL);
  assign out_data  = data_reg;
  assign out_sel   = sel_reg;
  assign beat_cnt  = beat_cnt_reg;

endmodule
